// File: rtl/fetch_pkg.sv
// Shared definitions for the IF-stage fetch sequencer: FSM encodings and PC arithmetic constants.
package fetch_pkg;

    typedef enum logic [1:0] {
        FS_BOOT = 2'd0,
        FS_RUN  = 2'd1,
        FS_HALT = 2'd2
    } fetch_state_t;

    localparam logic [31:0] PC_STEP    = 32'd4;
    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/fetch_pc_mux.sv
// Combinational next-PC priority select and flush strobe generation for the fetch sequencer.
module fetch_pc_mux
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  fetch_state_t state,
    input  logic [31:0]  pc_cur,
    input  logic         stall,
    input  logic         jmp_req,
    input  logic [31:0]  jmp_tgt,
    input  logic         br_req,
    input  logic [31:0]  br_tgt,
    input  logic         halt,
    input  logic         resume,
    output logic [31:0]  pc_next,
    output logic         flush_id,
    output logic         flush_ex
);

    logic [31:0] pc_inc;

    assign pc_inc = pc_cur + PC_STEP;

    // A branch from EX outranks everything: the younger ID instruction is on the wrong path.
    always_comb begin
        pc_next  = RESET_PC;
        flush_id = 1'b0;
        flush_ex = 1'b0;
        case (state)
            FS_RUN: begin
                if (br_req) begin
                    pc_next  = br_tgt & ALIGN_MASK;
                    flush_id = 1'b1;
                    flush_ex = 1'b1;
                end else if (halt || stall) begin
                    pc_next = pc_cur;
                end else if (jmp_req) begin
                    pc_next  = jmp_tgt & ALIGN_MASK;
                    flush_id = 1'b1;
                end else begin
                    pc_next = pc_inc;
                end
            end
            FS_HALT: pc_next = resume ? pc_inc : pc_cur;
            default: pc_next = RESET_PC;
        endcase
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer top: BOOT/RUN/HALT FSM, boot delay counter and IF-valid register.
// Optional FETCH_PERF_EN adds saturating redirect and stall counters.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          BOOT_CYC = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_cur_i,
    input  logic        stall_i,
    input  logic        jmp_req_i,
    input  logic [31:0] jmp_tgt_i,
    input  logic        br_req_i,
    input  logic [31:0] br_tgt_i,
    input  logic        halt_i,
    input  logic        resume_i,
    output logic [31:0] pc_next_o,
    output logic        flush_id_o,
    output logic        flush_ex_o,
    output logic        if_valid_o,
`ifdef FETCH_PERF_EN
    output logic [31:0] redirect_cnt_o,
    output logic [31:0] stall_cnt_o,
`endif
    output logic [1:0]  state_o
);

    localparam logic [3:0] BOOT_INIT = 4'(BOOT_CYC - 1);

    fetch_state_t state;
    fetch_state_t state_next;
    logic [3:0]   boot_cnt;
    logic         redirect_evt;
    logic         stall_evt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FS_BOOT;
            boot_cnt   <= BOOT_INIT;
            if_valid_o <= 1'b0;
        end else begin
            state      <= state_next;
            if_valid_o <= (state_next == FS_RUN);
            if (state == FS_BOOT && boot_cnt != 4'd0) begin
                boot_cnt <= boot_cnt - 4'd1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            FS_BOOT: if (boot_cnt == 4'd0) state_next = FS_RUN;
            FS_RUN:  if (!br_req_i && halt_i) state_next = FS_HALT;
            FS_HALT: if (resume_i) state_next = FS_RUN;
            default: state_next = FS_BOOT;
        endcase
    end

    // In RUN, flush_id is raised exactly by a branch or by a jump that was not suppressed.
    always_comb begin
        state_o      = state;
        redirect_evt = (state == FS_RUN) && flush_id_o;
        stall_evt    = (state == FS_RUN) && stall_i && !br_req_i;
    end

    fetch_pc_mux #(
        .RESET_PC (RESET_PC)
    ) u_pc_mux (
        .state    (state),
        .pc_cur   (pc_cur_i),
        .stall    (stall_i),
        .jmp_req  (jmp_req_i),
        .jmp_tgt  (jmp_tgt_i),
        .br_req   (br_req_i),
        .br_tgt   (br_tgt_i),
        .halt     (halt_i),
        .resume   (resume_i),
        .pc_next  (pc_next_o),
        .flush_id (flush_id_o),
        .flush_ex (flush_ex_o)
    );

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_cnt_o <= 32'd0;
            stall_cnt_o    <= 32'd0;
        end else begin
            if (redirect_evt && redirect_cnt_o != 32'hFFFF_FFFF) begin
                redirect_cnt_o <= redirect_cnt_o + 32'd1;
            end
            if (stall_evt && stall_cnt_o != 32'hFFFF_FFFF) begin
                stall_cnt_o <= stall_cnt_o + 32'd1;
            end
        end
    end
`else
    logic unused_evt;
    assign unused_evt = redirect_evt ^ stall_evt;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl (RESET_PC=0, BOOT_CYC=2); FETCH_PERF_EN also checks the counters.
module tb_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc_cur;
    logic        stall;
    logic        jmp_req;
    logic [31:0] jmp_tgt;
    logic        br_req;
    logic [31:0] br_tgt;
    logic        halt;
    logic        resume;
    logic [31:0] pc_next;
    logic        flush_id;
    logic        flush_ex;
    logic        if_valid;
    logic [1:0]  state;
`ifdef FETCH_PERF_EN
    logic [31:0] redirect_cnt;
    logic [31:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    fetch_ctrl #(
        .RESET_PC (32'h0000_0000),
        .BOOT_CYC (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc_cur_i       (pc_cur),
        .stall_i        (stall),
        .jmp_req_i      (jmp_req),
        .jmp_tgt_i      (jmp_tgt),
        .br_req_i       (br_req),
        .br_tgt_i       (br_tgt),
        .halt_i         (halt),
        .resume_i       (resume),
        .pc_next_o      (pc_next),
        .flush_id_o     (flush_id),
        .flush_ex_o     (flush_ex),
        .if_valid_o     (if_valid),
`ifdef FETCH_PERF_EN
        .redirect_cnt_o (redirect_cnt),
        .stall_cnt_o    (stall_cnt),
`endif
        .state_o        (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Advance to 2 time units after the next rising edge; inputs change here, checks follow #1 later.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        stall   = 1'b0;
        jmp_req = 1'b0;
        jmp_tgt = 32'h0;
        br_req  = 1'b0;
        br_tgt  = 32'h0;
        halt    = 1'b0;
        resume  = 1'b0;
    endtask

    initial begin
        rst_n  = 1'b0;
        pc_cur = 32'h0;
        clear_inputs();
        #12;
        check("rst_state", 32'(state), 32'd0);
        check("rst_if_valid", 32'(if_valid), 32'd0);
        br_req = 1'b1;
        br_tgt = 32'h500;
        #1;
        check("rst_pc_next", pc_next, 32'h0);
        check("rst_flush_ex", 32'(flush_ex), 32'd0);
`ifdef FETCH_PERF_EN
        check("rst_redirect_cnt", redirect_cnt, 32'd0);
        check("rst_stall_cnt", stall_cnt, 32'd0);
`endif
        clear_inputs();

        // Boot: two cycles at RESET_PC with requests ignored, then RUN.
        rst_n   = 1'b1;
        jmp_req = 1'b1;
        jmp_tgt = 32'h80;
        #1;
        check("boot1_pc_next", pc_next, 32'h0);
        check("boot1_flush_id", 32'(flush_id), 32'd0);
        tick();
        #1;
        check("boot2_state", 32'(state), 32'd0);
        check("boot2_pc_next", pc_next, 32'h0);
        check("boot2_if_valid", 32'(if_valid), 32'd0);
        clear_inputs();
        tick();
        #1;
        check("run_state", 32'(state), 32'd1);
        check("run_if_valid", 32'(if_valid), 32'd1);
        check("seq_pc0", pc_next, 32'h4);
        pc_cur = 32'h4;
        #1;
        check("seq_pc4", pc_next, 32'h8);

        // Stall suppresses a pending jump; releasing it lets the jump through.
        pc_cur  = 32'h20;
        stall   = 1'b1;
        jmp_req = 1'b1;
        jmp_tgt = 32'h80;
        #1;
        check("stall_pc_next", pc_next, 32'h20);
        check("stall_flush_id", 32'(flush_id), 32'd0);
        stall = 1'b0;
        #1;
        check("jmp_pc_next", pc_next, 32'h80);
        check("jmp_flush_id", 32'(flush_id), 32'd1);
        check("jmp_flush_ex", 32'(flush_ex), 32'd0);
        jmp_tgt = 32'h82;
        #1;
        check("jmp_align", pc_next, 32'h80);

        // Branch beats every other request.
        br_req = 1'b1;
        br_tgt = 32'h103;
        stall  = 1'b1;
        halt   = 1'b1;
        #1;
        check("br_pc_next", pc_next, 32'h100);
        check("br_flush_id", 32'(flush_id), 32'd1);
        check("br_flush_ex", 32'(flush_ex), 32'd1);
        tick();
        clear_inputs();
        #1;
        check("br_state_run", 32'(state), 32'd1);

        pc_cur = 32'hFFFF_FFFC;
        #1;
        check("wrap_pc_next", pc_next, 32'h0);

        // Halt, ignore a branch while halted, then resume.
        pc_cur = 32'h40;
        halt   = 1'b1;
        #1;
        check("halt_pc_next", pc_next, 32'h40);
        tick();
        halt = 1'b0;
        #1;
        check("halt_state", 32'(state), 32'd2);
        check("halt_if_valid", 32'(if_valid), 32'd0);
        br_req = 1'b1;
        br_tgt = 32'h200;
        #1;
        check("halt_br_pc_next", pc_next, 32'h40);
        check("halt_br_flush_ex", 32'(flush_ex), 32'd0);
        br_req = 1'b0;
        resume = 1'b1;
        #1;
        check("resume_pc_next", pc_next, 32'h44);
        tick();
        resume = 1'b0;
        #1;
        check("resume_state", 32'(state), 32'd1);
        check("resume_if_valid", 32'(if_valid), 32'd1);

        // Asynchronous reset while halted.
        halt = 1'b1;
        tick();
        halt = 1'b0;
        #1;
        check("halt2_state", 32'(state), 32'd2);
        rst_n = 1'b0;
        #1;
        check("rst_halt_state", 32'(state), 32'd0);
        check("rst_halt_pc_next", pc_next, 32'h0);
        check("rst_halt_if_valid", 32'(if_valid), 32'd0);
        rst_n = 1'b1;
        tick();
        tick();
        #1;
        check("reboot_state", 32'(state), 32'd1);

`ifdef FETCH_PERF_EN
        pc_cur  = 32'h10;
        jmp_req = 1'b1;
        jmp_tgt = 32'h60;
        tick();
        tick();
        tick();
        jmp_req = 1'b0;
        stall   = 1'b1;
        tick();
        stall = 1'b0;
        #1;
        check("perf_redirect_cnt", redirect_cnt, 32'd3);
        check("perf_stall_cnt", stall_cnt, 32'd1);
`endif

        // Asynchronous reset in the middle of a branch redirect.
        pc_cur = 32'h10;
        br_req = 1'b1;
        br_tgt = 32'h300;
        #1;
        check("midbr_flush_ex", 32'(flush_ex), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_br_state", 32'(state), 32'd0);
        check("rst_br_pc_next", pc_next, 32'h0);
        check("rst_br_flush_ex", 32'(flush_ex), 32'd0);
`ifdef FETCH_PERF_EN
        check("rst_br_redirect_cnt", redirect_cnt, 32'd0);
`endif
        clear_inputs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Fetch sequencer for the RV32 IF stage. It computes the next PC that the IF-stage PC register loads every cycle, and it arbitrates between the redirect sources: the sequential step, an ID-stage jump, an EX-stage taken branch, a hazard stall, and a halt. It also generates the pipeline flush strobes and the IF-valid qualifier, and it holds fetch in a boot state after reset while instruction ROM output settles.

## Interface
- RESET_PC, 32'h0000_0000: PC presented during BOOT and after reset.
- BOOT_CYC, 2: number of cycles spent in BOOT before fetch starts; legal range 1–15.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- pc_cur_i  in  32  current PC from the IF-stage PC register output.
- stall_i  in  1  load-use stall from the hazard unit; PC holds.
- jmp_req_i  in  1  jal redirect request from ID.
- jmp_tgt_i  in  32  jal target.
- br_req_i  in  1  taken-branch or jalr redirect request from EX.
- br_tgt_i  in  32  branch target.
- halt_i  in  1  ebreak decoded in ID (level).
- resume_i  in  1  leave HALT (debug/testbench).
- pc_next_o  out  32  drives the IF-stage PC register input.
- flush_id_o  out  1  kill the IF/ID register contents next edge.
- flush_ex_o  out  1  kill the ID/EX register contents next edge.
- if_valid_o  out  1  ROM output at the current PC is a real instruction.
- state_o  out  2  FSM state (BOOT=0, RUN=1, HALT=2).

## Operation
- The FSM has three states: BOOT, RUN, HALT.
- BOOT:
  - A 4-bit down-counter loads BOOT_CYC-1 on reset.
  - pc_next_o = RESET_PC. Flushes are 0. All requests are ignored.
  - When the counter reaches 0, the state moves to RUN.
- RUN: pc_next_o is chosen in this priority order.
  - br_req_i selects br_tgt_i. flush_id_o=1 and flush_ex_o=1. stall_i and halt_i are ignored that cycle, because the ID instruction is on the wrong path.
  - halt_i selects pc_cur_i, and the state moves to HALT.
  - stall_i selects pc_cur_i. jmp_req_i is suppressed; ID is held and re-asserts the request.
  - jmp_req_i selects jmp_tgt_i, with flush_id_o=1.
  - Otherwise pc_next_o = pc_cur_i + 4.
- HALT:
  - pc_next_o = pc_cur_i. Flushes are 0.
  - resume_i moves the state to RUN and gives pc_next_o = pc_cur_i + 4 in that cycle.
  - br_req_i in HALT is ignored.
- Arithmetic: the increment is 32-bit and wraps modulo 2^32 (32'hFFFF_FFFC steps to 0). Bits [1:0] of every selected target are forced to 0, since the ROM is word-addressed.
- pc_next_o, flush_id_o and flush_ex_o are combinational from state and inputs.
- if_valid_o is registered. It is 1 in every cycle where the state register is RUN, and 0 in BOOT and HALT.

## Timing
- Reset values: state BOOT, counter BOOT_CYC-1, if_valid_o 0, pc_next_o RESET_PC, flush_id_o 0, flush_ex_o 0, perf counters 0.
- Reset asserted mid-operation returns the block to BOOT immediately (asynchronous), whatever the pending requests.
- Redirect latency: a request in cycle N means the PC register holds the target at edge N+1. The flush strobe is in cycle N and kills the stage contents at edge N+1.
- The first if_valid_o=1 comes BOOT_CYC cycles after rst_n deasserts.
- A simultaneous br_req_i and jmp_req_i resolves to the branch; both flushes are asserted once.

## Configuration
- FETCH_PERF_EN defined: adds the following outputs, each saturating at 32'hFFFF_FFFF:
  - redirect_cnt_o (32): counts cycles in RUN with br_req_i or an effective jmp_req_i.
  - stall_cnt_o (32): counts RUN cycles with stall_i and no br_req_i.
- FETCH_PERF_EN undefined: those ports and counters are absent. All other behaviour is identical.

## Structure
- Shared package/header fetch_pkg:
  - state encodings FS_BOOT, FS_RUN, FS_HALT
  - PC_STEP = 32'd4
  - ALIGN_MASK = 32'hFFFF_FFFC
- Sub-module fetch_pc_mux: purely combinational priority select of pc_next_o and the flushes from the state and request inputs.
- The FSM, boot counter, if_valid_o register and perf counters live in fetch_ctrl.

## Test plan
- Reset, BOOT_CYC=2, RESET_PC=0 → pc_next_o=0 for 2 cycles, if_valid_o rises on cycle 3, then pc_next_o=pc_cur_i+4 (0,4,8,…).
- RUN, pc_cur_i=0x20, stall_i=1 and jmp_req_i=1 (jmp_tgt_i=0x80) → pc_next_o=0x20, flush_id_o=0. Deassert stall_i → pc_next_o=0x80, flush_id_o=1.
- br_req_i=1 (br_tgt_i=0x103), jmp_req_i=1, stall_i=1, halt_i=1 together → pc_next_o=0x100, flush_id_o=1, flush_ex_o=1, state stays RUN.
- pc_cur_i=0xFFFF_FFFC, no requests → pc_next_o=0.
- halt_i=1 at pc_cur_i=0x40 → state HALT, pc_next_o=0x40, if_valid_o=0 next cycle. Then resume_i=1 → pc_next_o=0x44, RUN.
- Drop rst_n in HALT, and separately mid-redirect → state BOOT and pc_next_o=RESET_PC immediately. With FETCH_PERF_EN defined, counters are 0 after reset and count 3 after three jumps.
